// File: rtl/sevenseg_scan_n_if.sv
// Bundle between the datapath side and the seven-segment scanner.
// The master drives digit codes and strobes; the slave returns the
// active-low pin image and the frame marker.
interface sevenseg_scan_n_if #(
   parameter int NDIGITS = 8
);
   logic                   en;
   logic                   load;
   logic [7*NDIGITS-1:0]   d;
   logic [NDIGITS-1:0]     an_n;
   logic [6:0]             segs_n;
   logic                   dp_n;
   logic                   frame_done;

   modport master (
      output en, load, d,
      input  an_n, segs_n, dp_n, frame_done
   );

   modport slave (
      input  en, load, d,
      output an_n, segs_n, dp_n, frame_done
   );
endinterface

// File: rtl/sevenseg_scan_n.sv
// Time-multiplexed driver for an NDIGITS common-anode seven-segment display.
// Codes are double-buffered in a shadow register on a load strobe; a
// divider dwells CLK_DIV cycles on each digit. All pin outputs are
// registered and active-low.
module sevenseg_scan_n #(
   parameter int NDIGITS = 8,
   parameter int CLK_DIV = 100000
) (
   input logic              clk,
   input logic              rst,
   sevenseg_scan_n_if.slave bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [6:0]       BLANK_CODE = 7'b100_0000;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIGITS - 1);

   generate
      if (NDIGITS < 1 || NDIGITS > 16 || CLK_DIV < 2) begin : g_bad_params
         $error("sevenseg_scan_n: NDIGITS must be 1..16 and CLK_DIV >= 2");
      end
   endgenerate

   logic [DIV_W-1:0]   div;
   logic [IDX_W-1:0]   idx;
   logic [6:0]         shadow [NDIGITS];

   logic [NDIGITS-1:0] an_q;
   logic [6:0]         segs_q;
   logic               dp_q;
   logic               fd_q;

   logic [6:0]         cur_code;
   logic [6:0]         hex_segs;
   logic [6:0]         seg_on;
   logic               dp_lit;
   logic [NDIGITS-1:0] an_next;
   logic               tick;
   logic               last;

   assign tick = (div == DIV_LAST);
   assign last = (idx == IDX_LAST);

   // Shadow buffer: whole word captured at once so digits never tear.
   // NOTE: the shadow is a small register file, not a RAM, so it is reset
   // to blank; otherwise the first frame after reset would show garbage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NDIGITS; i++) shadow[i] <= BLANK_CODE;
      end else if (bus.load) begin
         for (int i = 0; i < NDIGITS; i++) shadow[i] <= bus.d[7*i +: 7];
      end
   end

   // Decode the selected digit: blank beats dash beats hex; dp needs no blank.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      cur_code = shadow[idx];
      hex_segs = 7'h00;
      an_next  = '1;
      an_next[idx] = 1'b0;
      case (cur_code[3:0])
         4'h0: hex_segs = 7'h7E;
         4'h1: hex_segs = 7'h30;
         4'h2: hex_segs = 7'h6D;
         4'h3: hex_segs = 7'h79;
         4'h4: hex_segs = 7'h33;
         4'h5: hex_segs = 7'h5B;
         4'h6: hex_segs = 7'h5F;
         4'h7: hex_segs = 7'h70;
         4'h8: hex_segs = 7'h7F;
         4'h9: hex_segs = 7'h73;
         4'hA: hex_segs = 7'h77;
         4'hB: hex_segs = 7'h1F;
         4'hC: hex_segs = 7'h4E;
         4'hD: hex_segs = 7'h3D;
         4'hE: hex_segs = 7'h4F;
         default: hex_segs = 7'h47;
      endcase
      if (cur_code[6])      seg_on = 7'h00;
      else if (cur_code[4]) seg_on = 7'h01;
      else                  seg_on = hex_segs;
      dp_lit = cur_code[5] & ~cur_code[6];
   end

   // Divider, digit index and registered pin image; en=0 parks the scan dark.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div    <= '0;
         idx    <= '0;
         an_q   <= '1;
         segs_q <= 7'h7F;
         dp_q   <= 1'b1;
         fd_q   <= 1'b0;
      end else if (!bus.en) begin
         div    <= '0;
         idx    <= '0;
         an_q   <= '1;
         segs_q <= 7'h7F;
         dp_q   <= 1'b1;
         fd_q   <= 1'b0;
      end else begin
         div    <= tick ? '0 : div + DIV_W'(1);
         if (tick) idx <= last ? '0 : idx + IDX_W'(1);
         fd_q   <= tick & last;
         an_q   <= an_next;
         segs_q <= ~seg_on;
         dp_q   <= ~dp_lit;
      end
   end

   assign bus.an_n       = an_q;
   assign bus.segs_n     = segs_q;
   assign bus.dp_n       = dp_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Self-checking bench for sevenseg_scan_n (4 digits, 4-cycle dwell).
// A reference model predicts the pin image before each edge; predictions
// go through a scoreboard queue and are compared half a cycle later.
// Directed checks with literal values cover the documented scenarios.
module tb_sevenseg_scan_n;

   localparam int ND = 4;
   localparam int CD = 4;

   typedef struct packed {
      logic          fd;
      logic          dp_n;
      logic [6:0]    segs_n;
      logic [ND-1:0] an_n;
   } out_t;

   logic clk;
   logic rst;

   sevenseg_scan_n_if #(.NDIGITS(ND)) bus ();

   sevenseg_scan_n #(.NDIGITS(ND), .CLK_DIV(CD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   out_t sb [$];

   int         m_cnt;
   int         m_idx;
   logic [6:0] m_sh [ND];

   logic [3:0] an_lit  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
   logic [6:0] seg_lit [4] = '{7'h01, 7'h4F, 7'h12, 7'h06};
   logic [6:0] dec_code [4] = '{7'h2A, 7'h1A, 7'h6A, 7'h0D};
   logic [6:0] dec_seg  [4] = '{7'h08, 7'h7E, 7'h7F, 7'h42};
   logic       dec_dp   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
         4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
         4'h8: return 7'h7F;  4'h9: return 7'h73;  4'hA: return 7'h77;  4'hB: return 7'h1F;
         4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
      endcase
   endfunction

   function automatic out_t dark();
      out_t o;
      o.fd = 1'b0; o.dp_n = 1'b1; o.segs_n = 7'h7F; o.an_n = '1;
      return o;
   endfunction

   function automatic out_t dut_out();
      out_t o;
      o.fd = bus.frame_done; o.dp_n = bus.dp_n; o.segs_n = bus.segs_n; o.an_n = bus.an_n;
      return o;
   endfunction

   // Pin image the next edge should produce, from model state and current inputs.
   function automatic out_t model_out();
      out_t       o;
      logic [6:0] code;
      logic [6:0] lit;
      o = dark();
      if (bus.en) begin
         code = m_sh[m_idx];
         if (code[6])      lit = 7'h00;
         else if (code[4]) lit = 7'h01;
         else              lit = hex_seg(code[3:0]);
         o.an_n        = '1;
         o.an_n[m_idx] = 1'b0;
         o.segs_n      = ~lit;
         o.dp_n        = ~(code[5] & ~code[6]);
         o.fd          = (m_cnt == CD - 1) && (m_idx == ND - 1);
      end
      return o;
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_idx = 0;
      for (int i = 0; i < ND; i++) m_sh[i] = 7'h40;
   endtask

   task automatic model_advance();
      if (bus.load)
         for (int i = 0; i < ND; i++) m_sh[i] = bus.d[7*i +: 7];
      if (!bus.en) begin
         m_cnt = 0;
         m_idx = 0;
      end else if (m_cnt == CD - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % ND;
      end else begin
         m_cnt++;
      end
   endtask

   // One clock: predict, clock, advance model, compare on the falling edge.
   task automatic step();
      out_t got;
      sb.push_back(model_out());
      @(posedge clk);
      model_advance();
      @(negedge clk);
      got = dut_out();
      check("scan", got, sb.pop_front());
      bus.load = 1'b0;
   endtask

   task automatic load_word(input logic [6:0] c3, input logic [6:0] c2,
                            input logic [6:0] c1, input logic [6:0] c0);
      bus.d    = {c3, c2, c1, c0};
      bus.load = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_fd;
      int second_fd;
      int n_fd;
      bit found;

      rst      = 1'b1;
      bus.en   = 1'b1;
      bus.load = 1'b0;
      bus.d    = '0;
      model_reset();

      // Reset held three cycles with en=1.
      repeat (3) begin
         @(negedge clk);
         check("rst_hold", dut_out(), dark());
      end
      rst = 1'b0;
      step();
      check("rst_first", {bus.an_n, bus.segs_n, bus.dp_n}, {4'hE, 7'h7F, 1'b1});

      // Scan order with digits {3,2,1,0}, restarted cleanly from en=0.
      bus.en = 1'b0;
      load_word(7'h03, 7'h02, 7'h01, 7'h00);
      step();
      bus.en    = 1'b1;
      first_fd  = -1;
      second_fd = -1;
      n_fd      = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         check("scan_an",  bus.an_n,   an_lit[(k / 4) % 4]);
         check("scan_seg", bus.segs_n, seg_lit[(k / 4) % 4]);
         if (bus.frame_done) begin
            if (n_fd == 0)      first_fd  = k;
            else if (n_fd == 1) second_fd = k;
            n_fd++;
         end
      end
      check("fd_count",  n_fd, 2);
      check("fd_first",  first_fd, 15);
      check("fd_period", second_fd - first_fd, 16);

      // Decode priority on digit 0.
      for (int i = 0; i < 4; i++) begin
         bus.en = 1'b0;
         load_word(7'h40, 7'h40, 7'h40, dec_code[i]);
         step();
         bus.en = 1'b1;
         step();
         check("dec_an",  bus.an_n,   4'hE);
         check("dec_seg", bus.segs_n, dec_seg[i]);
         check("dec_dp",  bus.dp_n,   dec_dp[i]);
      end

      // Load coinciding with the digit0->1 tick: digit1 changes 5 -> 9.
      bus.en = 1'b0;
      load_word(7'h03, 7'h02, 7'h05, 7'h00);
      step();
      bus.en = 1'b1;
      repeat (3) step();
      load_word(7'h03, 7'h02, 7'h09, 7'h00);
      step();
      check("lt_pre_an", bus.an_n, 4'hE);
      step();
      check("lt_an",  bus.an_n,   4'hD);
      check("lt_seg", bus.segs_n, 7'h0C);

      // en dropped mid-scan on digit 2; load while dark is retained.
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_idx == 2 && m_cnt == 2) found = 1'b1;
         else step();
      end
      check("find_idx2", found, 1);
      bus.en = 1'b0;
      load_word(7'h01, 7'h01, 7'h01, 7'h08);
      step();
      check("off_pins", dut_out(), dark());
      step();
      bus.en = 1'b1;
      step();
      check("on_an",  bus.an_n,   4'hE);
      check("on_seg", bus.segs_n, 7'h00);
      repeat (3) step();
      check("dwell_an", bus.an_n, 4'hE);
      step();
      check("dwell_next_an",  bus.an_n,   4'hD);
      check("dwell_next_seg", bus.segs_n, 7'h4F);

      // Asynchronous reset between edges on digit 3, with a load pending.
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_idx == 3 && m_cnt == 1) found = 1'b1;
         else step();
      end
      check("find_idx3", found, 1);
      check("pre_rst_an", bus.an_n, 4'h7);
      load_word(7'h02, 7'h02, 7'h02, 7'h02);
      #2 rst = 1'b1;
      #1 check("async_rst", dut_out(), dark());
      model_reset();
      @(negedge clk);
      bus.load = 1'b0;
      rst      = 1'b0;
      step();
      check("post_rst_an",  bus.an_n,   4'hE);
      check("post_rst_seg", bus.segs_n, 7'h7F);
      repeat (3) step();
      step();
      check("post_rst_idx1_an",  bus.an_n,   4'hD);
      check("post_rst_idx1_seg", bus.segs_n, 7'h7F);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan_n.md
Name: sevenseg_scan_n

Overview:
- Parametrised, time-multiplexed driver for an NDIGITS-wide common-anode seven-segment display. Outputs are active-low.
- Each digit takes a 7-bit extended code: hex value, dash, decimal point and blank.
- Codes are captured into a shadow buffer on a load strobe, so the display never shows a half-updated word.
- A clock divider scans one digit at a time. The block sits between datapath/status logic and the board display pins.

Parameters:
NDIGITS, 8, number of digits scanned (legal 1..16)
CLK_DIV, 100000, clk cycles each digit stays lit (legal >= 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  1 = scan active; 0 = display dark, scan held
load  input  1  1-cycle strobe; capture d into shadow buffer
d  input  7*NDIGITS  digit i code at d[7*i+6:7*i]; bits [3:0] hex, [4] dash, [5] dp, [6] blank
an_n  output  NDIGITS  active-low digit enables, one-hot-low while scanning
segs_n  output  7  active-low segments, bit6..0 = a,b,c,d,e,f,g
dp_n  output  1  active-low decimal point
frame_done  output  1  1-cycle pulse when the scan wraps from last digit to digit 0

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high. Every register below resets asynchronously.
- Reset values:
  - div counter 0, idx 0.
  - Every shadow digit = 7'b100_0000 (blank).
  - an_n all 1, segs_n 7'h7F, dp_n 1, frame_done 0.
- Shadow buffer: on a clk edge with load=1, all of d is copied into the shadow. load has no effect on div or idx.
- Divider: div counts 0..CLK_DIV-1. The cycle with div==CLK_DIV-1 is a tick, and div returns to 0 after it.
- Digit index on tick:
  - idx advances by 1, wrapping from NDIGITS-1 to 0.
  - frame_done=1 in the cycle following a wrap tick, otherwise 0.
  - With NDIGITS=1, idx stays 0 and frame_done pulses after every tick.
- Decode, applied to shadow[idx], with segment bits a..g:
  - Hex values: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=73 A=77 b=1F C=4E d=3D E=4F F=47.
  - Dash bit=1 overrides hex with 01 (g only).
  - Blank bit=1 overrides everything: segs 00, dp off.
  - dp lit iff dp bit=1 and blank bit=0.
- Output registers: an_n, segs_n, dp_n and frame_done are all registered. Each edge they are loaded from the current idx and shadow:
  - an_n[idx]=0, all other an_n bits 1.
  - segs_n = ~decoded segments.
  - dp_n = ~dp_lit.
- Latency:
  - load at edge t: new data appears on outputs at edge t+1.
  - Tick at edge t: next digit's an_n/segs_n appear at edge t+1.
- Simultaneous load and tick: both take effect at the same edge. At the following edge the new idx is displayed with the new shadow data.
- en=0:
  - div and idx forced to 0, frame_done 0.
  - an_n all 1, segs_n 7'h7F, dp_n 1 at the next edge.
  - Shadow still accepts load.
- en rising: scanning restarts at digit 0 with a full CLK_DIV dwell.
- rst asserted mid-scan or mid-load: all outputs go to reset values immediately (asynchronous), and the shadow returns to blank. No pending load survives.
- Out-of-range parameters are illegal; elaboration must fail via a generate-time check.

Test Plan:
- Reset: assert rst for 3 cycles with en=1 -> an_n=all 1, segs_n=7F, dp_n=1, frame_done=0. After release, first digit outputs show blank (an_n[0]=0, segs_n=7F).
- Scan order: NDIGITS=4, CLK_DIV=4, en=1, load d={3,2,1,0} (digit0=0):
  - an_n cycles 1110,1101,1011,0111, each held exactly 4 cycles.
  - segs_n = 01,4F,12,06 respectively.
  - frame_done pulses once per 16 cycles, 1 cycle after the digit-3 tick.
- Decode priority on digit0:
  - code 7'h2A -> segs_n=08, dp_n=0.
  - code 7'h1A -> segs_n=7E.
  - code 7'h6A -> segs_n=7F, dp_n=1.
  - code 7'h0D -> segs_n=42.
- Load coinciding with tick: change digit1 from 5 to 9 on the digit0->1 tick edge -> first digit1 cycle shows segs_n=0C (9), never 24 (5).
- en low mid-scan at idx=2:
  - Next edge: all an_n=1, segs_n=7F.
  - load while en=0 is retained.
  - On en=1, an_n[0]=0 with the new data, and the first tick occurs after 4 cycles.
- Async reset mid-frame: pulse rst between edges at idx=3 -> outputs go to reset values without a clk edge, shadow is blank, and the scan restarts at digit 0.
